// File: rtl/neopixel_frame_sequencer.sv
// Frame sequencer for the NeoPixel strip: streams buffered pixel words to the serializer, then times the latch interval.
// Optional feature macro NEOPIXEL_DOUBLE_BUFFER_EN: host writes a back bank that is copied to the front bank at frame start.
module neopixel_frame_sequencer #(
  parameter int PIXELS_MAX  = 3,
  parameter int PIXELS_BITS = 2,
  parameter int RESET_TICKS = 500,
  parameter int RESET_BITS  = 9
) (
  input  logic                   clk_10mhz_i,
  input  logic                   reset_n_i,
  input  logic                   bus_we_i,
  input  logic [PIXELS_BITS-1:0] bus_addr_i,
  input  logic [23:0]            bus_wdata_i,
  input  logic [PIXELS_BITS:0]   cfg_pixels_i,
  input  logic                   start_i,
  input  logic                   continuous_i,
  output logic [23:0]            pixel_data_o,
  output logic                   pixel_valid_o,
  input  logic                   pixel_ready_i,
  input  logic                   ser_busy_i,
  output logic                   busy_o,
  output logic                   in_reset_o,
  output logic                   frame_done_o
);

  // state        | meaning
  // S_IDLE       | no frame in progress, waiting for START or CONTINUOUS
  // S_SEND       | presenting pixel words to the serializer
  // S_DRAIN      | last word accepted, waiting for the serializer to finish shifting
  // S_RESET_WAIT | strip latch interval, data line held low
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_RESET_WAIT} state_e;

  localparam int                    SLOTS         = 2 ** PIXELS_BITS;
  localparam logic [PIXELS_BITS:0]  MAX_CNT       = (PIXELS_BITS + 1)'(PIXELS_MAX);
  localparam logic [RESET_BITS-1:0] TC_LAST       = RESET_BITS'(RESET_TICKS - 1);
  localparam logic [RESET_BITS-1:0] TC_PRE        = RESET_BITS'(RESET_TICKS - 2);
  localparam logic                  DONE_ON_ENTRY = (RESET_TICKS == 1);

  state_e                  state_q;
  logic [PIXELS_BITS:0]    count_q;
  logic [PIXELS_BITS-1:0]  idx_q;
  logic [RESET_BITS-1:0]   tick_q;
  logic [23:0]             data_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    in_reset_q;
  logic                    done_q;

  logic [23:0]             back_q [SLOTS];

  logic                    wr_ok;
  logic                    launch;
  logic                    last_tick;
  logic                    more_px;
  logic [PIXELS_BITS:0]    cfg_clip;
  logic [PIXELS_BITS-1:0]  idx_nxt;
  logic [23:0]             first_word;
  logic [23:0]             next_word;

  assign wr_ok     = bus_we_i && ({1'b0, bus_addr_i} < MAX_CNT);
  assign last_tick = (state_q == S_RESET_WAIT) && (tick_q == TC_LAST);
  assign launch    = ((state_q == S_IDLE) || last_tick) && (start_i || continuous_i);
  assign cfg_clip  = (cfg_pixels_i > MAX_CNT) ? MAX_CNT : cfg_pixels_i;
  assign idx_nxt   = idx_q + PIXELS_BITS'(1);
  assign more_px   = ({1'b0, idx_q} + (PIXELS_BITS + 1)'(1)) < count_q;

  // Pixel store has no reset; contents are undefined until the host writes them.
  always_ff @(posedge clk_10mhz_i) begin
    if (wr_ok) begin
      back_q[bus_addr_i] <= bus_wdata_i;
    end
  end

`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
  logic [23:0] front_q [SLOTS];
  logic        dirty_q;
  logic        swap;

  assign swap = launch && dirty_q;

  always_ff @(posedge clk_10mhz_i) begin
    if (swap) begin
      front_q <= back_q;
    end
  end

  // A write landing on the swap edge is not in the copy, so it keeps the bank dirty.
  always_ff @(posedge clk_10mhz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dirty_q <= 1'b0;
    end else begin
      dirty_q <= wr_ok || (dirty_q && !swap);
    end
  end

  assign first_word = dirty_q ? back_q[0] : front_q[0];
  assign next_word  = front_q[idx_nxt];
`else
  assign first_word = back_q[0];
  assign next_word  = back_q[idx_nxt];
`endif

  always_ff @(posedge clk_10mhz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_reset_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        // Shared by the idle start and the restart from the final latch cycle.
        count_q <= cfg_clip;
        idx_q   <= '0;
        tick_q  <= '0;
        busy_q  <= 1'b1;
        if (cfg_clip == '0) begin
          state_q    <= S_RESET_WAIT;
          in_reset_q <= 1'b1;
          valid_q    <= 1'b0;
          done_q     <= DONE_ON_ENTRY;
        end else begin
          state_q    <= S_SEND;
          in_reset_q <= 1'b0;
          data_q     <= first_word;
          valid_q    <= 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          S_SEND: begin
            if (pixel_ready_i) begin
              if (more_px) begin
                idx_q  <= idx_nxt;
                data_q <= next_word;
              end else begin
                valid_q <= 1'b0;
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (!ser_busy_i) begin
              state_q    <= S_RESET_WAIT;
              tick_q     <= '0;
              in_reset_q <= 1'b1;
              done_q     <= DONE_ON_ENTRY;
            end
          end
          S_RESET_WAIT: begin
            if (last_tick) begin
              state_q    <= S_IDLE;
              tick_q     <= '0;
              in_reset_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              tick_q <= tick_q + RESET_BITS'(1);
              done_q <= (tick_q == TC_PRE);
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pixel_data_o  = data_q;
  assign pixel_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign in_reset_o    = in_reset_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Scoreboard bench for neopixel_frame_sequencer: expected pixel/frame-end stream queued by stimulus, checked by a monitor.
module tb_neopixel_frame_sequencer;

  localparam int PM = 3;
  localparam int RT = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  cfg = '0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        ready = 1'b1;
  logic        ser_busy = 1'b0;
  logic [23:0] data;
  logic        valid;
  logic        busy;
  logic        in_reset;
  logic        done;

  neopixel_frame_sequencer #(
    .PIXELS_MAX (3),
    .PIXELS_BITS(2),
    .RESET_TICKS(500),
    .RESET_BITS (9)
  ) dut (
    .clk_10mhz_i  (clk),
    .reset_n_i    (rst_n),
    .bus_we_i     (we),
    .bus_addr_i   (addr),
    .bus_wdata_i  (wdata),
    .cfg_pixels_i (cfg),
    .start_i      (start),
    .continuous_i (cont),
    .pixel_data_o (data),
    .pixel_valid_o(valid),
    .pixel_ready_i(ready),
    .ser_busy_i   (ser_busy),
    .busy_o       (busy),
    .in_reset_o   (in_reset),
    .frame_done_o (done)
  );

  always #50 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_q[$];          // pixel values; -1 marks the end of a frame
  logic [23:0] mem [PM];          // host's view of the pixel slots
  int          rmode = 0;         // 0 ready=1, 1 random, 2 pattern 1,0,0,1, 3 ready=0
  int          pidx = 0;
  bit [0:3]    pat = 4'b1001;
  bit          xfer_flag = 1'b0;
  int          ser_cnt = 0;

  task automatic chk(input string nm, input bit ok, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Ready pattern and a serializer that stays busy a few cycles after each accepted word.
  always @(posedge clk) begin
    #2;
    case (rmode)
      0: ready = 1'b1;
      1: ready = 1'($urandom_range(0, 1));
      2: begin ready = pat[pidx % 4]; pidx++; end
      default: ready = 1'b0;
    endcase
    if (xfer_flag) begin
      ser_cnt = $urandom_range(2, 9);
      xfer_flag = 1'b0;
    end else if (ser_cnt > 0) begin
      ser_cnt--;
    end
    ser_busy = (ser_cnt > 0);
  end

  logic [23:0] data_p = '0;
  bit valid_p = 0, ready_p = 0, in_reset_p = 0, done_p = 0, ser_busy_p = 0, restart_p = 0;
  int run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      valid_p = 0; ready_p = 0; in_reset_p = 0; done_p = 0; restart_p = 0; run = 0;
    end else begin
      if (valid_p && !ready_p) begin
        chk("stall_valid", valid, valid, 1);
        chk("stall_data", data == data_p, data, data_p);
      end
      if (valid_p && !valid)
        chk("valid_drop_not_frame_end", exp_q.size() > 0 && exp_q[0] == -1, valid, 1);
      if (valid && ready) begin
        xfer_flag = 1'b1;
        if (exp_q.size() == 0) chk("pixel_unexpected", 0, data, 0);
        else begin
          int e;
          e = exp_q.pop_front();
          chk("pixel_data", int'(data) == e, int'(data), e);
        end
      end
      if (in_reset && !in_reset_p)
        chk("latch_before_drain", !ser_busy_p, ser_busy_p, 0);
      if (in_reset) run++;
      if (done_p) begin
        chk("restart_busy", busy == restart_p, busy, restart_p);
        chk("restart_out", (valid || in_reset) == restart_p, valid || in_reset, restart_p);
      end
      if (!in_reset && in_reset_p)
        chk("latch_end_without_done", done_p, done_p, 1);
      if (done) begin
        chk("done_in_latch", in_reset, in_reset, 1);
        chk("latch_length", run == RT, run, RT);
        run = 0;
        if (exp_q.size() == 0) chk("done_unexpected", 0, 1, 0);
        else begin
          int e;
          e = exp_q.pop_front();
          chk("frame_end", e == -1, e, -1);
        end
      end
      valid_p = valid; ready_p = ready; data_p = data; in_reset_p = in_reset;
      done_p = done; ser_busy_p = ser_busy; restart_p = done && (start || cont);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [1:0] a, input logic [23:0] d);
    we = 1'b1; addr = a; wdata = d;
    if (int'(a) < PM) mem[a] = d;
    tick();
    we = 1'b0;
  endtask

  task automatic push_frame(input int n);
    int c;
    c = (n > PM) ? PM : n;
    for (int i = 0; i < c; i++) exp_q.push_back(int'(mem[i]));
    exp_q.push_back(-1);
  endtask

  task automatic start_frame(input logic [2:0] n);
    cfg = n;
    push_frame(int'(n));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin tick(); k++; end
    chk("idle_timeout", !busy, busy, 0);
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin tick(); k++; end
    chk("done_timeout", done, done, 1);
  endtask

  initial begin
    #(60000 * 100);
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #10 rst_n = 1'b0;
    #5;
    chk("rst_valid", valid == 0, valid, 0);
    chk("rst_data", data == 0, data, 0);
    chk("rst_busy", busy == 0, busy, 0);
    chk("rst_in_reset", in_reset == 0, in_reset, 0);
    chk("rst_done", done == 0, done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic frame, back-to-back words
    write_px(0, 24'hff00d5);
    write_px(1, 24'h008800);
    write_px(2, 24'h000090);
    rmode = 0;
    start_frame(3);
    wait_idle(1000);

    // Stalls with ready 1,0,0,1
    pidx = 0;
    rmode = 2;
    start_frame(3);
    wait_idle(1000);

    // Empty frame, then an over-long pixel count
    rmode = 0;
    start_frame(0);
    wait_idle(1000);
    start_frame(7);
    wait_idle(1000);

    // Continuous mode for two frames; START mid-frame is ignored
    rmode = 1;
    cfg = 3;
    push_frame(3);
    push_frame(3);
    cont = 1'b1;
    tick();
    wait_done(2000);
    repeat (5) tick();
    cont = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(2000);

    // Write to slot 1 while slot 0 is still being presented
    rmode = 3;
    cfg = 3;
    exp_q.push_back(int'(mem[0]));
`ifdef NEOPIXEL_DOUBLE_BUFFER_EN
    exp_q.push_back(int'(mem[1]));
`else
    exp_q.push_back(int'(24'h123456));
`endif
    exp_q.push_back(int'(mem[2]));
    exp_q.push_back(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    write_px(1, 24'h123456);
    tick();
    rmode = 0;
    wait_idle(1000);
    start_frame(3);
    wait_idle(1000);

    // Reset while the second pixel is presented
    rmode = 3;
    cfg = 3;
    push_frame(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    rmode = 0;
    tick();
    rmode = 3;
    #10;
    chk("pre_reset_px", valid && data == mem[1], data, mem[1]);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid == 0, valid, 0);
    chk("arst_busy", busy == 0, busy, 0);
    chk("arst_in_reset", in_reset == 0, in_reset, 0);
    chk("arst_data", data == 0, data, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    rmode = 0;
    repeat (600) tick();
    chk("post_reset_idle", busy == 0, busy, 0);
    start_frame(3);
    wait_idle(1000);

    // Randomized frames, including writes to the out-of-range slot
    for (int r = 0; r < 12; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) write_px(2'($urandom_range(0, 3)), 24'($urandom));
      rmode = $urandom_range(0, 1);
      start_frame(3'($urandom_range(0, 7)));
      wait_idle(3000);
    end

    repeat (5) tick();
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_sequencer.md
Name: neopixel_frame_sequencer

Overview:
Frame-level controller for the NeoPixel strip. It holds a host-writable pixel buffer and feeds 24-bit pixel words to the bit serializer over a valid/ready handshake. After the last pixel has been fully shifted out, it times the low "latch/reset" interval. It then signals frame completion, and either idles or restarts when in continuous mode. It sits between the host/config logic and the pixel serializer that drives NEO_DATA.

Parameters:
PIXELS_MAX, 3, number of pixel slots in the buffer (≥1).
PIXELS_BITS, 2, buffer address width; 2**PIXELS_BITS ≥ PIXELS_MAX.
RESET_TICKS, 500, clock cycles of reset interval (50 µs at 10 MHz).
RESET_BITS, 9, counter width; 2**RESET_BITS > RESET_TICKS.

Ports:
CLK_10MHZ  in  1  system clock, all logic on rising edge.
RESET_N  in  1  asynchronous, active-low reset.
BUS_WE  in  1  pixel buffer write strobe.
BUS_ADDR  in  PIXELS_BITS  pixel slot to write.
BUS_WDATA  in  24  pixel value, BRG order as used by the serializer.
CFG_PIXELS  in  PIXELS_BITS+1  pixels per frame, latched at frame start.
START  in  1  single-cycle frame request.
CONTINUOUS  in  1  level; restart automatically after each frame.
PIXEL_DATA  out  24  pixel word to serializer.
PIXEL_VALID  out  1  PIXEL_DATA is valid.
PIXEL_READY  in  1  serializer accepts the word when VALID&READY.
SER_BUSY  in  1  serializer still shifting bits.
BUSY  out  1  frame in progress (any state other than IDLE).
IN_RESET  out  1  high during reset interval (drives VERBOSE_STATE).
FRAME_DONE  out  1  one-cycle pulse at end of reset interval.

Behaviour:
- Reset (async, RESET_N=0): state IDLE; PIXEL_VALID=0, PIXEL_DATA=0, BUSY=0, IN_RESET=0, FRAME_DONE=0; counters 0. Buffer contents are not reset (undefined). The outputs drop immediately, without waiting for a clock edge. Reset mid-frame abandons the frame and no FRAME_DONE is produced.
- Writes: on BUS_WE, buf[BUS_ADDR] <= BUS_WDATA. BUS_ADDR ≥ PIXELS_MAX is ignored. Writes are accepted in every state, and the new value is visible to the next fetch of that slot.
- States: IDLE, SEND, DRAIN, RESET_WAIT.
- IDLE: when START=1 or CONTINUOUS=1:
  - latch count = min(CFG_PIXELS, PIXELS_MAX);
  - idx = 0.
  - If count=0, go to RESET_WAIT directly.
  - Otherwise go to SEND; on the next edge PIXEL_DATA=buf[0] and PIXEL_VALID=1.
- SEND: PIXEL_DATA and PIXEL_VALID are held stable while READY=0. On a transfer:
  - if idx < count-1: idx++, and PIXEL_DATA=buf[idx+1] on the next edge; VALID stays 1 (back-to-back, no bubble);
  - else: VALID <= 0 and go to DRAIN.
- DRAIN: wait until SER_BUSY=0, then enter RESET_WAIT with counter=0.
- RESET_WAIT: IN_RESET=1; the counter increments each cycle.
  - When counter = RESET_TICKS-1: FRAME_DONE=1 for that cycle.
  - The next state is SEND/IDLE re-evaluated with the IDLE rule, i.e. a continuous restart with a fresh latch of CFG_PIXELS. START seen in this cycle also restarts.
  - The interval is exactly RESET_TICKS cycles with IN_RESET=1.
- START while BUSY and not in the final RESET_WAIT cycle: ignored, not queued.
- CONTINUOUS deasserted mid-frame: the current frame completes, then the block goes to IDLE.
- BUSY=1 in SEND, DRAIN and RESET_WAIT.

Optional Feature:
Macro NEOPIXEL_DOUBLE_BUFFER_EN.
- With it: two banks. BUS_WE writes the back bank only. At each frame start (IDLE→SEND/RESET_WAIT transition), banks swap only if at least one write occurred since the last swap. The front bank stays stable for the whole frame, so there is no tearing.
- Without it: single bank. A write to a slot not yet fetched in the current frame appears in that frame.

Test Plan:
1. Write slots 0..2 = ff00d5, 008800, 000090; CFG_PIXELS=3; START; READY always 1 → PIXEL_DATA sequence ff00d5, 008800, 000090 on three consecutive cycles. After SER_BUSY falls, IN_RESET is high for exactly 500 cycles and FRAME_DONE pulses once on the last of them; then IDLE.
2. Same frame with READY toggling 1,0,0,1 → DATA/VALID held stable during stalls; no pixel skipped or duplicated.
3. CFG_PIXELS=0, START → no VALID; IN_RESET for 500 cycles; FRAME_DONE. CFG_PIXELS=7 → exactly 3 pixels sent.
4. CONTINUOUS=1 for two frames → second frame's VALID rises the cycle after the first FRAME_DONE. A START pulse mid-frame is ignored.
5. Assert RESET_N=0 mid-SEND (second pixel) → VALID, BUSY and IN_RESET go 0 asynchronously; no FRAME_DONE. After release, a START sends from slot 0.
6. (NEOPIXEL_DOUBLE_BUFFER_EN) Write slot 1 = 123456 during frame → current frame sends 008800; next frame sends 123456. Without the macro, the same write made before slot 1 is fetched → current frame sends 123456.
